add4_seq_accum: RTL and testbench
=================================

Name: add4_seq_accum

Overview:
- Sequential operand/result stage wrapped around the 4-bit ripple adder.
- Drives the adder's a/b inputs from registers and waits a fixed number of cycles for the gate-level carry chain to settle.
- Captures sum and carry-out into an accumulator and returns the result on a valid/ready handshake.
- Sits directly upstream (operand feed) and downstream (result capture) of the adder instance.

Parameters:
SETTLE_CYCLES, 4, cycles the adder outputs must settle before capture; legal range 1..15
CNT_W, 4, width of the settle counter; must satisfy 2^CNT_W > SETTLE_CYCLES

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  command valid
in_ready  output  1  block can accept a command
in_op  input  2  00 ADD, 01 LOAD, 10 CLR, 11 reserved
in_data  input  4  operand for ADD/LOAD
add_a  output  4  to adder a3..a0; always equals acc register
add_b  output  4  to adder b3..b0; always equals operand register
add_s  input  4  from adder s3..s0
add_c4  input  1  from adder c4
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_sum  output  4  accumulator value
out_carry  output  1  carry-out of the last ADD; 0 after LOAD/CLR
out_ovf  output  1  sticky overflow; set by any ADD with carry-out, cleared only by CLR or rst
out_err  output  1  last command was the reserved op

Behaviour:
- Interface decision: one clock, `clk`; reset `rst` is synchronous and active-high.
- Reset state: IDLE; acc=0, opnd=0, carry=0, ovf=0, err=0, cnt=0.
- Reset outputs: in_ready=1, out_valid=0.
- Reset overrides everything in any state, including mid-SETTLE and mid-RESP. Any pending result is discarded.
- FSM states: IDLE, SETTLE, RESP.
- in_ready is 1 only in IDLE. out_valid is 1 only in RESP. Both are registered-state decodes; there is no combinational path from in_valid to in_ready.
- IDLE, on accept (in_valid & in_ready):
  - ADD: opnd<=in_data, cnt<=SETTLE_CYCLES-1, err<=0, go to SETTLE.
  - LOAD: acc<=in_data, carry<=0, err<=0, go to RESP. ovf is unchanged.
  - CLR: acc<=0, carry<=0, ovf<=0, err<=0, go to RESP.
  - 11 (reserved): err<=1, go to RESP. acc, carry and ovf are unchanged.
- IDLE with no valid command: hold all registers.
- SETTLE:
  - cnt!=0: cnt<=cnt-1.
  - cnt==0: acc<=add_s, carry<=add_c4, ovf<=ovf|add_c4, go to RESP.
  - Net effect: SETTLE lasts exactly SETTLE_CYCLES cycles.
- ADD latency: accepted at edge k, so out_valid is first high after edge k+SETTLE_CYCLES+1. LOAD/CLR/reserved: out_valid is high after edge k+1.
- RESP: out_sum=acc, out_carry=carry, out_ovf=ovf, out_err=err, all held stable while out_valid=1 and out_ready=0. When out_ready=1, go to IDLE.
- No same-cycle turnaround: a new command is accepted no earlier than the cycle after the result handshake.
- Arithmetic: modulo 16. The carry-out is reported, never folded into acc.
- out_* signals are driven from registers at all times, including in IDLE (last values shown).
- add_a/add_b change only on an accept or a capture. They are stable during SETTLE, which guarantees settled adder outputs at capture.
- in_op and in_data are ignored when no accept occurs.

Decomposition:
- Shared package add4_pkg:
  - op encodings OP_ADD=2'b00, OP_LOAD=2'b01, OP_CLR=2'b10, OP_RSV=2'b11
  - state encodings S_IDLE=2'b00, S_SETTLE=2'b01, S_RESP=2'b10
  - data width constant 4
- No sub-module needed. The adder is instantiated by the parent alongside this block, not inside it, so the bench can substitute a behavioural adder with configurable delay.

Test Plan:
- rst, then LOAD 5, then ADD 3, out_ready=1 -> out_sum=8, carry=0, ovf=0. out_valid rises 5 cycles after the ADD accept (SETTLE_CYCLES=4).
- From acc=8, ADD 9 -> out_sum=1, carry=1, ovf=1. Then ADD 2 -> out_sum=3, carry=0, ovf remains 1.
- CLR -> out_sum=0, carry=0, ovf=0, err=0; out_valid one cycle after accept.
- ADD 7 with out_ready held 0 for 6 cycles -> out_valid stays 1 and outputs stay constant; in_ready=0 and in_valid pulses are ignored. Raising out_ready returns the block to IDLE.
- Assert rst 2 cycles into SETTLE -> next cycle state is IDLE, in_ready=1, out_valid=0, acc=0, add_a=add_b=0. No result is ever presented.
- Reserved op with acc=6 -> out_err=1, out_sum=6. A following ADD 1 gives out_err=0, out_sum=7. Also sweep all 256 a/b pairs via LOAD/ADD against a reference model.

Source files
------------

// File: rtl/add4_pkg.sv
// rtl/add4_pkg.sv - shared encodings for the 4-bit adder operand/result stage
package add4_pkg;

  localparam int DATA_W = 4;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_CLR  = 2'b10;
  localparam logic [1:0] OP_RSV  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_SETTLE = 2'b01,
    S_RESP   = 2'b10
  } state_t;

endpackage

// File: rtl/add4_seq_accum_if.sv
// rtl/add4_seq_accum_if.sv - command and result handshake bundle of the accumulator stage
interface add4_seq_accum_if;
  import add4_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_op;
  logic [DATA_W-1:0] in_data;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_sum;
  logic              out_carry;
  logic              out_ovf;
  logic              out_err;

  modport master (
    output in_valid, in_op, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_ovf, out_err
  );

  modport slave (
    input  in_valid, in_op, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_ovf, out_err
  );

endinterface

// File: rtl/add4_seq_accum.sv
// rtl/add4_seq_accum.sv - feeds an external ripple adder from registers, waits for it to settle,
// and returns the captured sum/carry on a valid/ready handshake
module add4_seq_accum
  import add4_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 4
) (
  input  logic              clk,
  input  logic              rst,
  add4_seq_accum_if.slave   bus,
  output logic [DATA_W-1:0] add_a,
  output logic [DATA_W-1:0] add_b,
  input  logic [DATA_W-1:0] add_s,
  input  logic              add_c4
);

  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(SETTLE_CYCLES - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] opnd_q, opnd_d;
  logic              carry_q, carry_d;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      opnd_q  <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          case (bus.in_op)
            OP_ADD: begin
              opnd_d  = bus.in_data;
              cnt_d   = CNT_START;
              err_d   = 1'b0;
              state_d = S_SETTLE;
            end
            OP_LOAD: begin
              acc_d   = bus.in_data;
              carry_d = 1'b0;
              err_d   = 1'b0;
              state_d = S_RESP;
            end
            OP_CLR: begin
              acc_d   = '0;
              carry_d = 1'b0;
              ovf_d   = 1'b0;
              err_d   = 1'b0;
              state_d = S_RESP;
            end
            default: begin
              err_d   = 1'b1;
              state_d = S_RESP;
            end
          endcase
        end
      end
      S_SETTLE: begin
        // Adder inputs have been frozen for SETTLE_CYCLES cycles when cnt reaches zero.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          acc_d   = add_s;
          carry_d = add_c4;
          ovf_d   = ovf_q | add_c4;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_RESP);
  assign bus.out_sum   = acc_q;
  assign bus.out_carry = carry_q;
  assign bus.out_ovf   = ovf_q;
  assign bus.out_err   = err_q;

  assign add_a = acc_q;
  assign add_b = opnd_q;

endmodule

// File: tb/tb_add4_seq_accum.sv
// tb/tb_add4_seq_accum.sv - self-checking bench with a slow behavioural adder and a result scoreboard
module tb_add4_seq_accum;
  import add4_pkg::*;

  localparam int SETTLE = 4;

  typedef struct {
    logic [1:0] op;
    logic [3:0] data;
    logic [3:0] sum;
    logic       carry;
    logic       ovf;
    logic       err;
  } vec_t;

  typedef struct {
    logic [3:0] sum;
    logic       carry;
    logic       ovf;
    logic       err;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] add_a, add_b, add_s;
  logic       add_c4;

  add4_seq_accum_if bus ();

  add4_seq_accum #(.SETTLE_CYCLES(SETTLE), .CNT_W(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .add_a  (add_a),
    .add_b  (add_b),
    .add_s  (add_s),
    .add_c4 (add_c4)
  );

  always #5 clk = ~clk;

  // Adder outputs are wrong until its inputs have been stable long enough.
  logic [7:0] prev_ab = 8'h00;
  int         stable_cnt = 15;
  logic [4:0] true_sum;

  always @(negedge clk) begin
    prev_ab <= {add_a, add_b};
    if ({add_a, add_b} != prev_ab) stable_cnt <= 0;
    else if (stable_cnt < 15)      stable_cnt <= stable_cnt + 1;
  end

  always_comb begin
    true_sum = {1'b0, add_a} + {1'b0, add_b};
    if (stable_cnt >= SETTLE - 1) begin
      add_s  = true_sum[3:0];
      add_c4 = true_sum[4];
    end else begin
      add_s  = ~true_sum[3:0];
      add_c4 = ~true_sum[4];
    end
  end

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  logic [3:0] m_acc = 4'd0;
  logic       m_carry = 1'b0;
  logic       m_ovf = 1'b0;
  logic       m_err = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic exp_t model_step(input logic [1:0] op, input logic [3:0] data);
    exp_t       e;
    logic [4:0] s;
    e.lat = 1;
    case (op)
      OP_ADD: begin
        s       = {1'b0, m_acc} + {1'b0, data};
        m_acc   = s[3:0];
        m_carry = s[4];
        m_ovf   = m_ovf | s[4];
        m_err   = 1'b0;
        e.lat   = SETTLE + 1;
      end
      OP_LOAD: begin
        m_acc = data; m_carry = 1'b0; m_err = 1'b0;
      end
      OP_CLR: begin
        m_acc = 4'd0; m_carry = 1'b0; m_ovf = 1'b0; m_err = 1'b0;
      end
      default: m_err = 1'b1;
    endcase
    e.sum = m_acc; e.carry = m_carry; e.ovf = m_ovf; e.err = m_err;
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [3:0] data, input exp_t e, input bit push);
    int n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check("in_ready_timeout", 8'(bus.in_ready), 8'd1);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_data  = data;
    if (push) sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_op    = 2'($urandom_range(0, 3));
    bus.in_data  = 4'($urandom_range(0, 15));
  endtask

  task automatic collect(input string tag, input bit handshake);
    exp_t e;
    int   lat = 1;
    while (!bus.out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) begin
      check({tag, "_out_valid_timeout"}, 8'(bus.out_valid), 8'd1);
      return;
    end
    if (sb.size() == 0) begin
      check({tag, "_unexpected_result"}, 8'(sb.size()), 8'd1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_sum"},     8'(bus.out_sum),   8'(e.sum));
    check({tag, "_carry"},   8'(bus.out_carry), 8'(e.carry));
    check({tag, "_ovf"},     8'(bus.out_ovf),   8'(e.ovf));
    check({tag, "_err"},     8'(bus.out_err),   8'(e.err));
    check({tag, "_latency"}, 8'(lat),           8'(e.lat));
    if (handshake) begin
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
    end
  endtask

  vec_t vecs[8];
  exp_t e;

  initial begin
    vecs[0] = '{OP_LOAD, 4'd5, 4'd5, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{OP_ADD,  4'd3, 4'd8, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{OP_ADD,  4'd9, 4'd1, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{OP_ADD,  4'd2, 4'd3, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{OP_CLR,  4'd9, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{OP_LOAD, 4'd6, 4'd6, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{OP_RSV,  4'd3, 4'd6, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{OP_ADD,  4'd1, 4'd7, 1'b0, 1'b0, 1'b0};

    bus.in_valid  = 1'b0;
    bus.in_op     = 2'b00;
    bus.in_data   = 4'd0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready",  8'(bus.in_ready),  8'd1);
    check("rst_out_valid", 8'(bus.out_valid), 8'd0);
    check("rst_sum",       8'(bus.out_sum),   8'd0);
    check("rst_carry",     8'(bus.out_carry), 8'd0);
    check("rst_ovf",       8'(bus.out_ovf),   8'd0);
    check("rst_err",       8'(bus.out_err),   8'd0);
    check("rst_add_a",     8'(add_a),         8'd0);
    check("rst_add_b",     8'(add_b),         8'd0);

    for (int i = 0; i < 8; i++) begin
      e = model_step(vecs[i].op, vecs[i].data);
      e.sum = vecs[i].sum; e.carry = vecs[i].carry; e.ovf = vecs[i].ovf; e.err = vecs[i].err;
      issue(vecs[i].op, vecs[i].data, e, 1'b1);
      collect($sformatf("vec%0d", i), 1'b1);
      check($sformatf("vec%0d_idle", i), 8'(bus.in_ready), 8'd1);
    end

    // Backpressure: result must hold while out_ready is low, commands ignored.
    e = model_step(OP_ADD, 4'd7);
    issue(OP_ADD, 4'd7, e, 1'b1);
    collect("bp", 1'b0);
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_op    = OP_CLR;
      bus.in_data  = 4'd0;
      @(posedge clk);
      @(negedge clk);
      check("bp_out_valid", 8'(bus.out_valid), 8'd1);
      check("bp_in_ready",  8'(bus.in_ready),  8'd0);
      check("bp_sum",       8'(bus.out_sum),   8'd14);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("bp_release_valid", 8'(bus.out_valid), 8'd0);
    check("bp_release_ready", 8'(bus.in_ready),  8'd1);
    check("bp_release_sum",   8'(bus.out_sum),   8'd14);

    // Reset two cycles into SETTLE discards the pending ADD.
    e = '{4'd0, 1'b0, 1'b0, 1'b0, 0};
    issue(OP_ADD, 4'd5, e, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_acc = 4'd0; m_carry = 1'b0; m_ovf = 1'b0; m_err = 1'b0;
    check("mid_rst_in_ready",  8'(bus.in_ready),  8'd1);
    check("mid_rst_out_valid", 8'(bus.out_valid), 8'd0);
    check("mid_rst_sum",       8'(bus.out_sum),   8'd0);
    check("mid_rst_add_a",     8'(add_a),         8'd0);
    check("mid_rst_add_b",     8'(add_b),         8'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("mid_rst_no_result", 8'(bus.out_valid), 8'd0);
    end

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        e = model_step(OP_LOAD, 4'(a));
        issue(OP_LOAD, 4'(a), e, 1'b1);
        collect("sweep_load", 1'b1);
        e = model_step(OP_ADD, 4'(b));
        issue(OP_ADD, 4'(b), e, 1'b1);
        collect($sformatf("sweep_add_%0d_%0d", a, b), 1'b1);
      end
    end

    check("sb_empty", 8'(sb.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
